// File: rtl/frame_if.sv
// Word stream in, frame/outcome results out between the deframer and its neighbours.
// The slave side is the parser; the master side feeds words and observes results.
interface frame_if;
    logic [15:0]  data_in;
    logic         fifo_full;
    logic         frame_wr;
    logic [7:0]   frame_ch;
    logic [3:0]   frame_len;
    logic [127:0] frame_data;
    logic         crc_valid;
    logic         crc_err;
    logic         frame_drop;

    modport master (
        output data_in, fifo_full,
        input  frame_wr, frame_ch, frame_len, frame_data, crc_valid, crc_err, frame_drop
    );

    modport slave (
        input  data_in, fifo_full,
        output frame_wr, frame_ch, frame_len, frame_data, crc_valid, crc_err, frame_drop
    );
endinterface

// File: rtl/frame_parser.sv
// Receive deframer: finds the E0E0 E0E0 header, captures channel and payload, checks
// CRC-16/CCITT ahead of the 0E0E 0E0E trailer and issues one registered outcome pulse.
//
//   state   | meaning
//   HUNT    | looking for first header word
//   HEAD1   | one header word seen, expecting the second
//   CHAN    | next word is the one-hot channel
//   PAYLOAD | shifting words through the 3-deep delay line until trailer/oversize
module frame_parser (
    input  logic   clk_in,
    input  logic   rst_n,
    frame_if.slave fif
);
    typedef enum logic [1:0] {HUNT, HEAD1, CHAN, PAYLOAD} state_t;

    localparam logic [15:0] HDR_WORD = 16'hE0E0;
    localparam logic [15:0] TRL_WORD = 16'h0E0E;

    state_t         state_q, state_d;
    logic [15:0]    d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     ncom_q, ncom_d;
    logic [15:0]    crc_q, crc_d;
    logic [111:0]   data_q, data_d;
    logic [7:0]     ch_cap_q, ch_cap_d;
    logic [7:0]     ch_out_q, ch_out_d;
    logic [3:0]     len_out_q, len_out_d;
    logic [127:0]   dat_out_q, dat_out_d;
    logic           wr_q, wr_d, valid_q, valid_d, err_q, err_d, drop_q, drop_d;

    logic [3:0]     words_seen;
    logic [15:0]    crc_next;
    logic [127:0]   data_next;
    logic           is_hdr, is_trailer, chan_ok;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // d3 is the word committed this cycle; both trailer and normal commits use it
    assign words_seen = cnt_q + 4'd1;
    assign crc_next   = crc_step(crc_q, d3_q);
    assign data_next  = {data_q, d3_q};
    assign is_hdr     = (fif.data_in == HDR_WORD);
    assign is_trailer = (fif.data_in == TRL_WORD) && (d1_q == TRL_WORD) && (words_seen >= 4'd4);
    assign chan_ok    = (fif.data_in[15:8] == 8'h00) && (fif.data_in[7:0] != 8'h00) &&
                        ((fif.data_in[7:0] & (fif.data_in[7:0] - 8'd1)) == 8'h00);

    always_comb begin
        state_d   = state_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        d3_d      = d3_q;
        cnt_d     = cnt_q;
        ncom_d    = ncom_q;
        crc_d     = crc_q;
        data_d    = data_q;
        ch_cap_d  = ch_cap_q;
        ch_out_d  = ch_out_q;
        len_out_d = len_out_q;
        dat_out_d = dat_out_q;
        wr_d      = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        drop_d    = 1'b0;
        case (state_q)
            HUNT: begin
                if (is_hdr) state_d = HEAD1;
            end
            HEAD1: begin
                state_d = is_hdr ? CHAN : HUNT;
            end
            CHAN: begin
                if (chan_ok) begin
                    ch_cap_d = fif.data_in[7:0];
                    d1_d     = '0;
                    d2_d     = '0;
                    d3_d     = '0;
                    cnt_d    = '0;
                    ncom_d   = '0;
                    crc_d    = '0;
                    data_d   = '0;
                    state_d  = PAYLOAD;
                end else begin
                    drop_d  = 1'b1;
                    state_d = is_hdr ? HEAD1 : HUNT;
                end
            end
            PAYLOAD: begin
                cnt_d = words_seen;
                d1_d  = fif.data_in;
                d2_d  = d1_q;
                d3_d  = d2_q;
                if (is_trailer) begin
                    state_d = HUNT;
                    // a trailer landing on the 9th commit is still oversize
                    if (ncom_q == 4'd8 || fif.fifo_full) begin
                        drop_d = 1'b1;
                    end else if (d2_q == crc_next) begin
                        wr_d      = 1'b1;
                        valid_d   = 1'b1;
                        ch_out_d  = ch_cap_q;
                        len_out_d = ncom_q + 4'd1;
                        dat_out_d = data_next;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q >= 4'd3) begin
                    if (ncom_q == 4'd8) begin
                        drop_d  = 1'b1;
                        state_d = HUNT;
                    end else begin
                        crc_d  = crc_next;
                        data_d = data_next[111:0];
                        ncom_d = ncom_q + 4'd1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            cnt_q     <= '0;
            ncom_q    <= '0;
            crc_q     <= '0;
            data_q    <= '0;
            ch_cap_q  <= '0;
            ch_out_q  <= '0;
            len_out_q <= '0;
            dat_out_q <= '0;
            wr_q      <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            cnt_q     <= cnt_d;
            ncom_q    <= ncom_d;
            crc_q     <= crc_d;
            data_q    <= data_d;
            ch_cap_q  <= ch_cap_d;
            ch_out_q  <= ch_out_d;
            len_out_q <= len_out_d;
            dat_out_q <= dat_out_d;
            wr_q      <= wr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign fif.frame_wr   = wr_q;
    assign fif.frame_ch   = ch_out_q;
    assign fif.frame_len  = len_out_q;
    assign fif.frame_data = dat_out_q;
    assign fif.crc_valid  = valid_q;
    assign fif.crc_err    = err_q;
    assign fif.frame_drop = drop_q;
endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: hand-built frames with expected outcomes and payloads.
module tb_frame_parser;
    logic clk_in = 1'b0;
    logic rst_n;
    frame_if fif ();

    frame_parser dut (.clk_in(clk_in), .rst_n(rst_n), .fif(fif));

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_err = 0;
    int n_wr = 0, n_valid = 0, n_crcerr = 0, n_drop = 0;
    int b_wr, b_valid, b_crcerr, b_drop;
    logic [15:0] pl [8];
    logic [15:0] c;

    // pulses are counted independently of the directed checks to catch stray extras
    always @(posedge clk_in) begin
        n_wr     <= n_wr + int'(fif.frame_wr);
        n_valid  <= n_valid + int'(fif.crc_valid);
        n_crcerr <= n_crcerr + int'(fif.crc_err);
        n_drop   <= n_drop + int'(fif.frame_drop);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // long-division form: remainder of (crc ^ word) * x^16 by 0x11021
    function automatic logic [15:0] crc_model(input int n);
        logic [31:0] r;
        logic [15:0] acc;
        acc = 16'h0000;
        for (int k = 0; k < n; k++) begin
            r = {acc ^ pl[k], 16'h0000};
            for (int i = 31; i >= 16; i--)
                if (r[i]) r = r ^ (32'h0001_1021 << (i - 16));
            acc = r[15:0];
        end
        return acc;
    endfunction

    task automatic send_word(input logic [15:0] w);
        fif.data_in = w;
        @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [15:0] ch, input int n, input logic [15:0] crc);
        send_word(16'hE0E0);
        send_word(16'hE0E0);
        send_word(ch);
        for (int k = 0; k < n; k++) send_word(pl[k]);
        send_word(crc);
        send_word(16'h0E0E);
        send_word(16'h0E0E);
    endtask

    task automatic snap();
        b_wr = n_wr; b_valid = n_valid; b_crcerr = n_crcerr; b_drop = n_drop;
    endtask

    task automatic chk_counts(input string tag, input int wr, input int vl, input int er, input int dr);
        chk({tag, "_nwr"},    128'(n_wr - b_wr), 128'(wr));
        chk({tag, "_nvalid"}, 128'(n_valid - b_valid), 128'(vl));
        chk({tag, "_nerr"},   128'(n_crcerr - b_crcerr), 128'(er));
        chk({tag, "_ndrop"},  128'(n_drop - b_drop), 128'(dr));
    endtask

    initial begin
        rst_n = 1'b0;
        fif.data_in = 16'h0000;
        fif.fifo_full = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_wr",    128'(fif.frame_wr), 128'(0));
        chk("rst_valid", 128'(fif.crc_valid), 128'(0));
        chk("rst_err",   128'(fif.crc_err), 128'(0));
        chk("rst_drop",  128'(fif.frame_drop), 128'(0));
        chk("rst_ch",    128'(fif.frame_ch), 128'(0));
        chk("rst_len",   128'(fif.frame_len), 128'(0));
        chk("rst_data",  fif.frame_data, 128'(0));
        rst_n = 1'b1;
        repeat (2) send_word(16'h0000);

        // single good frame
        snap();
        pl[0] = 16'hA55A;
        send_frame(16'h0001, 1, 16'h1934);
        chk("good_wr",    128'(fif.frame_wr), 128'(1));
        chk("good_valid", 128'(fif.crc_valid), 128'(1));
        chk("good_err",   128'(fif.crc_err), 128'(0));
        chk("good_ch",    128'(fif.frame_ch), 128'(8'h01));
        chk("good_len",   128'(fif.frame_len), 128'(1));
        chk("good_data",  fif.frame_data, 128'(16'hA55A));
        send_word(16'h0000);
        chk("good_wr_1cyc",    128'(fif.frame_wr), 128'(0));
        chk("good_valid_1cyc", 128'(fif.crc_valid), 128'(0));
        send_word(16'h0000);
        chk_counts("good", 1, 1, 0, 0);

        // max-length frame twice, back to back
        snap();
        pl[0] = 16'h0123; pl[1] = 16'h4567; pl[2] = 16'h89AB; pl[3] = 16'hCDEF;
        pl[4] = 16'hFEDC; pl[5] = 16'hBA98; pl[6] = 16'h7654; pl[7] = 16'h3210;
        c = crc_model(8);
        for (int r = 0; r < 2; r++) begin
            send_frame(16'h0002, 8, c);
            chk("max_wr",   128'(fif.frame_wr), 128'(1));
            chk("max_ch",   128'(fif.frame_ch), 128'(8'h02));
            chk("max_len",  128'(fif.frame_len), 128'(8));
            chk("max_data", fif.frame_data, 128'h0123456789ABCDEFFEDCBA9876543210);
        end
        repeat (2) send_word(16'h0000);
        chk_counts("max", 2, 2, 0, 0);

        // bad CRC
        snap();
        pl[0] = 16'h1234;
        send_frame(16'h0001, 1, 16'hFFFF);
        chk("bad_err",  128'(fif.crc_err), 128'(1));
        chk("bad_wr",   128'(fif.frame_wr), 128'(0));
        chk("bad_hold_len",  128'(fif.frame_len), 128'(8));
        chk("bad_hold_data", fif.frame_data, 128'h0123456789ABCDEFFEDCBA9876543210);
        send_word(16'h0000);
        chk("bad_err_1cyc", 128'(fif.crc_err), 128'(0));
        send_word(16'h0000);
        chk_counts("bad", 0, 0, 1, 0);

        // invalid channel, then a normal frame
        snap();
        send_word(16'hE0E0);
        send_word(16'hE0E0);
        send_word(16'hE0E0);
        chk("badch_drop", 128'(fif.frame_drop), 128'(1));
        send_word(16'h0000);
        chk("badch_drop_1cyc", 128'(fif.frame_drop), 128'(0));
        pl[0] = 16'h1234;
        c = crc_model(1);
        send_frame(16'h0004, 1, c);
        chk("badch_next_wr",   128'(fif.frame_wr), 128'(1));
        chk("badch_next_ch",   128'(fif.frame_ch), 128'(8'h04));
        chk("badch_next_data", fif.frame_data, 128'(16'h1234));
        send_word(16'h0000);
        chk_counts("badch", 1, 1, 0, 1);

        // oversize: 16 payload words, drop on the 12th
        snap();
        send_word(16'hE0E0);
        send_word(16'hE0E0);
        send_word(16'h0020);
        for (int k = 0; k < 11; k++) send_word(16'hAAAA);
        chk("ovr_drop_early", 128'(fif.frame_drop), 128'(0));
        send_word(16'hAAAA);
        chk("ovr_drop", 128'(fif.frame_drop), 128'(1));
        for (int k = 0; k < 4; k++) send_word(16'hAAAA);
        send_word(16'h1145);
        send_word(16'h0E0E);
        send_word(16'h0E0E);
        repeat (2) send_word(16'h0000);
        chk_counts("ovr", 0, 0, 0, 1);

        // reset after the CRC word
        snap();
        pl[0] = 16'h5555;
        c = crc_model(1);
        send_word(16'hE0E0);
        send_word(16'hE0E0);
        send_word(16'h0008);
        send_word(16'h5555);
        send_word(c);
        rst_n = 1'b0;
        #1;
        chk("mrst_ch",  128'(fif.frame_ch), 128'(0));
        chk("mrst_len", 128'(fif.frame_len), 128'(0));
        fif.data_in = 16'h0000;
        @(negedge clk_in);
        rst_n = 1'b1;
        send_word(16'h0E0E);
        send_word(16'h0E0E);
        repeat (2) send_word(16'h0000);
        chk_counts("mrst", 0, 0, 0, 0);
        pl[0] = 16'hA55A;
        send_frame(16'h0080, 1, 16'h1934);
        chk("mrst_next_wr", 128'(fif.frame_wr), 128'(1));
        chk("mrst_next_ch", 128'(fif.frame_ch), 128'(8'h80));
        send_word(16'h0000);

        // FIFO full on the trailer
        snap();
        fif.fifo_full = 1'b1;
        send_frame(16'h0010, 1, 16'h1934);
        chk("full_drop",  128'(fif.frame_drop), 128'(1));
        chk("full_wr",    128'(fif.frame_wr), 128'(0));
        chk("full_valid", 128'(fif.crc_valid), 128'(0));
        chk("full_hold_ch", 128'(fif.frame_ch), 128'(8'h80));
        fif.fifo_full = 1'b0;
        repeat (2) send_word(16'h0000);
        chk_counts("full", 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
